// File: rtl/e_mem_loader_pkg.sv
// Shared definitions for the polynomial memory loader: default digit geometry,
// derived memory sizing helpers and the loader state encoding.
`ifndef M
`define M 8
`endif
`ifndef R
`define R 5
`endif
`ifndef D
`define D 2
`endif

package e_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic int calc_width(input int m, input int digit);
        return m * digit;
    endfunction

    function automatic int calc_depth(input int r, input int digit);
        return (r + digit - 1) / digit;
    endfunction

    // A single-word memory still needs a 1-bit address port.
    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/e_mem_loader_digit_packer.sv
// Packs incoming digits LSB-first into memory words and issues one registered
// write per completed word; the packing register restarts on the completing edge.
module digit_packer
    import e_mem_loader_pkg::*;
#(
    parameter int M     = 8,
    parameter int R     = 5,
    parameter int DIGIT = 1,
    parameter int WIDTH = calc_width(M, DIGIT),
    parameter int DEPTH = calc_depth(R, DIGIT),
    parameter int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept,
    input  logic [M-1:0]     data,
    output logic             last,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_dout
);

    localparam int PW = (DIGIT > 1) ? $clog2(DIGIT) : 1;
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [PW-1:0]    pos;
    logic [CW-1:0]    total;
    logic [AW-1:0]    word_idx;
    logic [WIDTH-1:0] pack_q;
    logic [WIDTH-1:0] pack_next;
    logic             word_end;

    always_comb begin
        pack_next = pack_q;
        pack_next[pos*M +: M] = data;
        last     = accept && (total == CW'(R - 1));
        word_end = accept && ((pos == PW'(DIGIT - 1)) || (total == CW'(R - 1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            total    <= '0;
            word_idx <= '0;
            pack_q   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_dout <= '0;
        end else begin
            mem_we <= word_end;
            if (accept) begin
                if (word_end) begin
                    mem_dout <= pack_next;
                    mem_addr <= word_idx;
                    pack_q   <= '0;
                    pos      <= '0;
                    // The final digit always lands in word DEPTH-1, so clearing
                    // here is the only way the index returns to zero.
                    word_idx <= last ? '0 : word_idx + 1'b1;
                end else begin
                    pack_q <= pack_next;
                    pos    <= pos + 1'b1;
                end
                total <= last ? '0 : total + 1'b1;
            end
        end
    end

endmodule

// File: rtl/e_mem_loader.sv
// Streams one polynomial into the hash core memory, then starts the hash core
// and captures its digest.
//   state | meaning
//   IDLE  | waiting for the first digit, memory owned by loader
//   LOAD  | accepting digits, writing completed words
//   FLUSH | final word write in flight
//   START | memory handed to hash core, start pulse
//   WAIT  | waiting for hash core completion
//   DONE  | digest captured, done pulse
module e_mem_loader
    import e_mem_loader_pkg::*;
#(
    parameter int M     = `M,
    parameter int R     = `R,
    parameter int DIGIT = 1,
    localparam int WIDTH = calc_width(M, DIGIT),
    localparam int DEPTH = calc_depth(R, DIGIT),
    localparam int AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [M-1:0]     s_data,
    output logic             mem_own,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_dout,
    output logic             hash_start,
    input  logic             hash_ready,
    input  logic [511:0]     hash_digest,
    output logic [511:0]     digest,
    output logic             done,
    output logic             busy
);

    if (DIGIT > R || DIGIT < 1) begin : g_bad_digit
        $error("e_mem_loader: DIGIT must be in 1..R");
    end

    state_t state;
    logic   hs;
    logic   last;

    assign hs   = s_valid && s_ready;
    assign busy = (state != IDLE);

    digit_packer #(
        .M     (M),
        .R     (R),
        .DIGIT (DIGIT),
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .accept   (hs),
        .data     (s_data),
        .last     (last),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_dout (mem_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            s_ready    <= 1'b0;
            hash_start <= 1'b0;
            done       <= 1'b0;
            digest     <= '0;
            mem_own    <= 1'b1;
        end else begin
            hash_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (hs) begin
                        // With R = 1 the first digit is also the last one.
                        state <= last ? FLUSH : LOAD;
                        if (last) s_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    if (hs && last) begin
                        state   <= FLUSH;
                        s_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    state      <= START;
                    hash_start <= 1'b1;
                    mem_own    <= 1'b0;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (hash_ready) begin
                        digest <= hash_digest;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    mem_own <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    mem_own <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mem_loader.sv
// Scoreboard bench for e_mem_loader: a DIGIT=2/R=5 instance and a DIGIT=1/R=4 instance.
module tb_e_mem_loader;

    logic         clk;
    logic         rst;

    logic         a_valid, a_ready, a_own, a_we, a_hstart, a_hready, a_done, a_busy;
    logic [7:0]   a_data;
    logic [1:0]   a_addr;
    logic [15:0]  a_dout;
    logic [511:0] a_hdig, a_digest;

    logic         b_valid, b_ready, b_own, b_we, b_hstart, b_hready, b_done, b_busy;
    logic [7:0]   b_data;
    logic [1:0]   b_addr;
    logic [7:0]   b_dout;
    logic [511:0] b_hdig, b_digest;

    logic [17:0]  a_q[$];
    logic [9:0]   b_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [511:0] DIG1 = {16{32'hDEADBEEF}};
    localparam logic [511:0] JUNK = {64{8'h3C}};
    localparam logic [511:0] DA5  = {64{8'hA5}};
    localparam logic [511:0] DIG3 = {16{32'h0BADF00D}};
    localparam logic [511:0] DIGB = {16{32'h13579BDF}};

    e_mem_loader #(.M(8), .R(5), .DIGIT(2)) dut_a (
        .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .mem_own(a_own), .mem_we(a_we), .mem_addr(a_addr), .mem_dout(a_dout),
        .hash_start(a_hstart), .hash_ready(a_hready), .hash_digest(a_hdig),
        .digest(a_digest), .done(a_done), .busy(a_busy)
    );

    e_mem_loader #(.M(8), .R(4), .DIGIT(1)) dut_b (
        .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .mem_own(b_own), .mem_we(b_we), .mem_addr(b_addr), .mem_dout(b_dout),
        .hash_start(b_hstart), .hash_ready(b_hready), .hash_digest(b_hdig),
        .digest(b_digest), .done(b_done), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            if (a_q.size() == 0) chk("a_extra_we", a_we, 0);
            else begin
                logic [17:0] e;
                e = a_q.pop_front();
                chk("a_wr_addr", a_addr, e[17:16]);
                chk("a_wr_data", a_dout, e[15:0]);
                chk("a_wr_own", a_own, 1);
            end
        end
        if (b_we === 1'b1) begin
            if (b_q.size() == 0) chk("b_extra_we", b_we, 0);
            else begin
                logic [9:0] e;
                e = b_q.pop_front();
                chk("b_wr_addr", b_addr, e[9:8]);
                chk("b_wr_data", b_dout, e[7:0]);
            end
        end
    end

    task automatic a_send(input logic [7:0] d);
        int n = 0;
        a_valid = 1'b1;
        a_data  = d;
        while (!a_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("a_ready_timeout", a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d);
        int n = 0;
        b_valid = 1'b1;
        b_data  = d;
        while (!b_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("b_ready_timeout", b_ready, 1);
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    // Expected words are queued before the completing digit is driven.
    task automatic a_stream(input logic [7:0] base, input int n, input int gap_at,
                            input int gap_len, input bit pulse, input logic [511:0] prev);
        logic [15:0] w;
        logic [7:0]  d;
        int pos, widx;
        w = '0; pos = 0; widx = 0;
        for (int k = 0; k < n; k++) begin
            d = base + 8'(k);
            w[pos*8 +: 8] = d;
            pos++;
            if (pos == 2 || k == 4) begin
                a_q.push_back({2'(widx), w});
                w = '0; pos = 0; widx++;
            end
            a_send(d);
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    if (pulse && g == 1) begin
                        a_hready = 1'b1;
                        a_hdig   = JUNK;
                    end
                    @(negedge clk);
                    a_hready = 1'b0;
                end
                if (pulse) begin
                    chk("a_ign_digest", a_digest, prev);
                    chk("a_ign_busy", a_busy, 1);
                    chk("a_ign_done", a_done, 0);
                end
            end
        end
    endtask

    task automatic a_finish(input logic [511:0] d);
        chk("a_flush_ready", a_ready, 0);
        chk("a_flush_own", a_own, 1);
        chk("a_flush_hstart", a_hstart, 0);
        @(negedge clk);
        chk("a_start_hstart", a_hstart, 1);
        chk("a_start_own", a_own, 0);
        chk("a_start_we", a_we, 0);
        @(negedge clk);
        chk("a_wait_hstart", a_hstart, 0);
        chk("a_wait_busy", a_busy, 1);
        a_hready = 1'b1;
        a_hdig   = d;
        @(negedge clk);
        a_hready = 1'b0;
        chk("a_done", a_done, 1);
        chk("a_digest", a_digest, d);
        @(negedge clk);
        chk("a_done_once", a_done, 0);
        chk("a_idle_busy", a_busy, 0);
        chk("a_idle_ready", a_ready, 1);
        chk("a_idle_own", a_own, 1);
        chk("a_digest_hold", a_digest, d);
        chk("a_q_empty", a_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_data = '0; a_hready = 1'b0; a_hdig = '0;
        b_valid = 1'b0; b_data = '0; b_hready = 1'b0; b_hdig = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", a_ready, 0);
        chk("rst_we", a_we, 0);
        chk("rst_hstart", a_hstart, 0);
        chk("rst_done", a_done, 0);
        chk("rst_addr", a_addr, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_digest", a_digest, 0);
        chk("rst_own", a_own, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_b_ready", b_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", a_ready, 1);
        chk("rel_b_ready", b_ready, 1);

        // back-to-back stream 01..05
        a_stream(8'h01, 5, -1, 0, 1'b0, '0);
        a_finish(DIG1);

        // 3-cycle gap after digit 03 with a stray hash_ready pulse
        a_stream(8'h01, 5, 2, 3, 1'b1, DIG1);
        a_finish(DA5);

        // reset after digit 03, then a fresh stream
        a_stream(8'h01, 3, -1, 0, 1'b0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_we", a_we, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_hstart", a_hstart, 0);
        chk("mid_rst_digest", a_digest, 0);
        chk("mid_rst_q", a_q.size(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rel_ready", a_ready, 1);
        a_stream(8'h11, 5, -1, 0, 1'b0, '0);
        a_finish(DIG3);

        // DIGIT=1, R=4 instance
        for (int k = 0; k < 4; k++) begin
            b_q.push_back({2'(k), 8'hA0 + 8'(k)});
            b_send(8'hA0 + 8'(k));
        end
        chk("b_flush_own", b_own, 1);
        chk("b_flush_hstart", b_hstart, 0);
        @(negedge clk);
        chk("b_start_hstart", b_hstart, 1);
        chk("b_start_own", b_own, 0);
        @(negedge clk);
        b_hready = 1'b1;
        b_hdig   = DIGB;
        @(negedge clk);
        b_hready = 1'b0;
        chk("b_done", b_done, 1);
        chk("b_digest", b_digest, DIGB);
        @(negedge clk);
        chk("b_idle_busy", b_busy, 0);
        chk("b_q_empty", b_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/e_mem_loader.md
E_MEM_LOADER -- requirements
Module: e_mem_loader

Interface
REQ-001 Parameters SHALL be: M, default `M, digit width in bits; R, default `R, digits per polynomial; DIGIT, default 1, digits per memory word.
REQ-002 Derived constants SHALL be: WIDTH = M*DIGIT; DEPTH = ceil(R/DIGIT); AW = clog2(DEPTH).
REQ-003 Ports, in order: clk in 1, the single clock.
REQ-004 rst in 1, reset; synchronous, active-high.
REQ-005 s_valid in 1, input digit valid.
REQ-006 s_ready out 1, loader accepts a digit.
REQ-007 s_data in M, one polynomial digit.
REQ-008 mem_own out 1, loader owns the memory port; the external mux selects the loader when high, otherwise the hash core.
REQ-009 mem_we out 1, memory write strobe.
REQ-010 mem_addr out AW, write address.
REQ-011 mem_dout out WIDTH, write data.
REQ-012 hash_start out 1, one-cycle start pulse to the hash core in_ready.
REQ-013 hash_ready in 1, hash core out_ready.
REQ-014 hash_digest in 512, hash core digest.
REQ-015 digest out 512, captured digest.
REQ-016 done out 1, one-cycle completion pulse.
REQ-017 busy out 1, high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, FLUSH, START, WAIT and DONE.
REQ-019 A handshake SHALL occur when s_valid and s_ready are both high; s_ready SHALL be high in IDLE and LOAD only.
REQ-020 A handshake in IDLE SHALL move the FSM to LOAD; that first digit counts toward the R digits.
REQ-021 Digits SHALL be packed LSB-first: digit k of a word occupies bits [k*M+M-1 : k*M].
REQ-022 A word SHALL complete on the DIGIT-th digit, or on digit R overall; unfilled high digits of the last word SHALL be zero.
REQ-023 On the cycle after a word completes, mem_we SHALL be 1 for exactly one cycle, with mem_addr = word index (0..DEPTH-1) and mem_dout = the packed word.
REQ-024 The packing register SHALL restart on the same edge a word completes, so input is never stalled for a write.
REQ-025 After digit R is accepted, the FSM SHALL enter FLUSH and perform the final write there.
REQ-026 From FLUSH the FSM SHALL go to START; hash_start SHALL be 1 for one cycle in START, and mem_own SHALL already be 0 in START.
REQ-027 mem_own SHALL be 1 in IDLE, LOAD and FLUSH, and 0 otherwise.
REQ-028 In WAIT, on hash_ready = 1, digest SHALL capture hash_digest and the FSM SHALL go to DONE.
REQ-029 In DONE, done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-030 digest SHALL hold its value until the next capture.
REQ-031 hash_ready outside WAIT SHALL be ignored.
REQ-032 s_valid low mid-word SHALL leave the partial word and counters unchanged.
REQ-033 Write addresses SHALL stop at DEPTH-1 and never wrap within one load; they restart at 0 on the next load.
REQ-034 DIGIT = 1 SHALL produce one write per digit; DIGIT > R SHALL be rejected by an elaboration check.

Reset
REQ-035 While rst is high at a clock edge: state = IDLE; s_ready = 0; mem_we = 0; hash_start = 0; done = 0; mem_addr = 0; mem_dout = 0; digest = 0; counters = 0; mem_own = 1.
REQ-036 Reset mid-load or mid-hash SHALL discard the partial word and issue no further writes or start pulse.
REQ-037 s_ready SHALL go high on the first cycle after rst is released.

Structure
REQ-038 WIDTH, DEPTH and AW derivation and the state encoding SHALL live in the shared package alongside the `M/`R/`D definitions.
REQ-039 Digit packing and the digit/word counters SHALL be one sub-module, digit_packer; the FSM and hash handshake SHALL live in e_mem_loader.

Verification
Example configuration for REQ-040 to REQ-042: M=8, R=5, DIGIT=2, DEPTH=3.
REQ-040 Stream digits 01..05 back-to-back -> three writes: addr0 = 0x0201, addr1 = 0x0403, addr2 = 0x0005; then hash_start pulses in the cycle after the FLUSH write.
REQ-041 Same stream with s_valid low for 3 cycles after digit 03 -> identical memory contents; no extra or early mem_we.
REQ-042 hash_ready pulsed during LOAD, then hash_ready pulsed with hash_digest = 512'hA5..A5 in WAIT -> first pulse ignored; digest = A5..A5; done high exactly one cycle later; busy low the following cycle.
REQ-043 rst asserted after digit 03 -> no further mem_we; state IDLE; a fresh stream 11..15 writes 0x1211, 0x1413, 0x0015 from address 0.
REQ-044 DIGIT=1, R=4 -> four writes at addresses 0..3; mem_own falls in the START cycle.
